// File: rtl/bp_update_sched_pkg.sv
// Shared types for the branch-predictor update scheduler.
package bp_update_sched_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // One resolved-branch update as queued for the predictor.
  typedef struct packed {
    word_t pc;
    word_t bt;
    logic  taken;
  } bp_update_t;

  localparam int unsigned BP_UPDATE_W = $bits(bp_update_t);

endpackage

// File: rtl/bp_update_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last advanced grant.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Scan requesters from ptr, wrapping mod N, and grant the first valid one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
      scan_idx = (scan_idx == PW'(N - 1)) ? '0 : scan_idx + PW'(1);
    end
    ptr_nxt = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
  end

  // Pointer moves past the granted index only when the grant is actually taken.
  always_ff @(posedge CLK) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// Funnels branch-resolution updates from NREQ units into the single predictor update port.
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_pc,
  input  logic [NREQ*WORD_W-1:0]   req_bt,
  input  logic [NREQ-1:0]          req_taken,
  input  logic                     upd_ready,
  output logic [WORD_W-1:0]        pc_res,
  output logic [WORD_W-1:0]        bt_res,
  output logic                     taken_res,
  output logic                     enable_res,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  bp_update_t     mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [OW-1:0]  occ_q;

  logic [NREQ-1:0] grant;
  logic            can_accept;
  logic            push;
  logic            pop;
  bp_update_t      push_data;
  bp_update_t      head;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .CLK     (CLK),
    .rst     (rst),
    .req     (req_valid),
    .advance (push),
    .grant   (grant)
  );

  // Accept/drain qualification; a full FIFO never accepts even if it pops this cycle.
  always_comb begin
    can_accept = (occ_q < OW'(DEPTH)) && !flush && !rst;
    push       = can_accept && (|grant);
    req_ready  = can_accept ? grant : '0;
    pop        = (occ_q != '0) && upd_ready && !flush && !rst;
  end

  // Select the granted requester's payload.
  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        push_data.pc    = req_pc[i*WORD_W +: WORD_W];
        push_data.bt    = req_bt[i*WORD_W +: WORD_W];
        push_data.taken = req_taken[i];
      end
    end
  end

  // Head presented combinationally; zeroed while empty so stale entries never leak.
  always_comb begin
    head       = (occ_q != '0) ? mem[rd_ptr] : '0;
    pc_res     = head.pc;
    bt_res     = head.bt;
    taken_res  = head.taken;
    enable_res = pop;
    occupancy  = occ_q;
  end

  // Pointers and count; reset and flush both discard every queued entry.
  always_ff @(posedge CLK) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Entry storage; written on the accepting edge, no reset needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: table of hand-derived cycle vectors plus a queue scoreboard.
module tb_bp_update_sched;
  import bp_update_sched_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WORD_W-1:0] req_pc;
  logic [NREQ*WORD_W-1:0] req_bt;
  logic [NREQ-1:0]        req_taken;
  logic                   upd_ready;
  logic [WORD_W-1:0]      pc_res;
  logic [WORD_W-1:0]      bt_res;
  logic                   taken_res;
  logic                   enable_res;
  logic [2:0]             occupancy;

  bp_update_sched #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .req_bt     (req_bt),
    .req_taken  (req_taken),
    .upd_ready  (upd_ready),
    .pc_res     (pc_res),
    .bt_res     (bt_res),
    .taken_res  (taken_res),
    .enable_res (enable_res),
    .occupancy  (occupancy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       r;
    logic       f;
    logic [1:0] v;
    logic       u;
    logic [1:0] rdy;
    logic       en;
    logic [2:0] occ;
  } vec_t;

  vec_t       tbl [28];
  bp_update_t sb [$];
  int         rr_m;
  int         n0;
  int         n1;
  word_t      base0;
  word_t      base1;
  logic       wrap_mode;
  int         wrap_k;
  int         compared;
  int         mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the scoreboard model (and table row), then advance the model.
  task automatic do_cycle(input logic r, input logic f, input logic [1:0] v, input logic u,
                          input logic use_exp, input logic [1:0] e_rdy, input logic e_en,
                          input logic [2:0] e_occ);
    word_t      p0;
    word_t      p1;
    logic [1:0] m_rdy;
    logic       m_en;
    int         g;
    int         idx;
    bp_update_t head_m;
    bp_update_t ent;
    p0 = base0 + word_t'(4 * n0);
    p1 = base1 + word_t'(4 * n1);
    rst       = r;
    flush     = f;
    req_valid = v;
    upd_ready = u;
    req_pc    = {p1, p0};
    req_bt    = {p1 + 32'h40, p0 + 32'h40};
    req_taken = {n1[0], ~n0[0]};
    @(negedge CLK);
    g = -1;
    if (!r && !f && (sb.size() < int'(DEPTH))) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        idx = (rr_m + i) % int'(NREQ);
        if (g < 0 && v[idx]) g = idx;
      end
    end
    m_rdy  = (g >= 0) ? (2'b01 << g) : 2'b00;
    m_en   = (sb.size() != 0) && u && !f && !r;
    head_m = (sb.size() != 0) ? sb[0] : '0;
    check("req_ready", 32'(req_ready), 32'(m_rdy));
    check("enable_res", 32'(enable_res), 32'(m_en));
    check("occupancy", 32'(occupancy), 32'(sb.size()));
    check("pc_res", pc_res, head_m.pc);
    check("bt_res", bt_res, head_m.bt);
    check("taken_res", 32'(taken_res), 32'(head_m.taken));
    if (use_exp) begin
      check("tbl_ready", 32'(req_ready), 32'(e_rdy));
      check("tbl_enable", 32'(enable_res), 32'(e_en));
      check("tbl_occ", 32'(occupancy), 32'(e_occ));
    end
    if (wrap_mode && enable_res) begin
      check("wrap_order", pc_res, word_t'(4 * wrap_k));
      wrap_k++;
    end
    if (r) begin
      sb.delete();
      rr_m = 0;
    end else if (f) begin
      sb.delete();
    end else begin
      if (m_en) void'(sb.pop_front());
      if (g >= 0) begin
        ent.pc    = (g == 0) ? p0 : p1;
        ent.bt    = ent.pc + 32'h40;
        ent.taken = (g == 0) ? ~n0[0] : n1[0];
        sb.push_back(ent);
        rr_m = (g + 1) % int'(NREQ);
        if (g == 0) n0++;
        else        n1++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rr_m       = 0;
    n0         = 0;
    n1         = 0;
    base0      = 32'h100;
    base1      = 32'h800;
    wrap_mode  = 1'b0;
    wrap_k     = 0;

    //          r     f     v      u     rdy    en    occ
    // single update through the pipe
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 3'd1};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 3'd0};
    // alternating grants into a stalled predictor until full
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b10, 1'b0, 3'd1};
    tbl[7]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 3'd2};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b10, 1'b0, 3'd3};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 3'd4};
    // full: pop without accept, then steady push+pop
    tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 3'd4};
    tbl[11] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 3'd3};
    tbl[12] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 3'd3};
    tbl[13] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 3'd3};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 3'd3};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 3'd2};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 3'd1};
    tbl[17] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 3'd0};
    // three queued, flush, rotation continues from requester 1
    tbl[18] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 3'd0};
    tbl[19] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 3'd1};
    tbl[20] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 3'd2};
    tbl[21] = '{1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 3'd3};
    tbl[22] = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b10, 1'b0, 3'd0};
    tbl[23] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd1};
    // reset with two queued; RR pointer returns to requester 0
    tbl[24] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 3'd1};
    tbl[25] = '{1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 3'd2};
    tbl[26] = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 3'd0};
    tbl[27] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd1};

    for (int i = 0; i < 28; i++) begin
      do_cycle(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].u, 1'b1, tbl[i].rdy, tbl[i].en, tbl[i].occ);
    end

    // Wrap-around: ten updates with PCs 0x0..0x24 and irregular predictor stalls.
    base0 = 32'h0;
    n0    = 0;
    do_cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
    wrap_mode = 1'b1;
    for (int c = 0; c < 200 && n0 < 10; c++) begin
      do_cycle(1'b0, 1'b0, 2'b01, ($urandom_range(0, 2) != 0), 1'b0, 2'b00, 1'b0, 3'd0);
    end
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      do_cycle(1'b0, 1'b0, 2'b00, ($urandom_range(0, 3) != 0), 1'b0, 2'b00, 1'b0, 3'd0);
    end
    check("wrap_accepts", 32'(n0), 32'd10);
    check("wrap_pops", 32'(wrap_k), 32'd10);
    wrap_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
